apb_uart_fifo: RTL
==================

Name: apb_uart_fifo

Overview:
Second-generation APB-attached UART. Adds parametrised data width, runtime parity/stop-bit modes, TX and RX FIFOs, sticky error flags and an interrupt output. Sits on the APB bus as a peripheral selected by a psel code, alongside the GPIO slave, and drives/receives the board serial pins.

Parameters:
CLOCK_RATE, 50_000_000, board clock in Hz
BAUD_RATE, 9600, line rate; bit period BAUD_DIV = CLOCK_RATE/BAUD_RATE clocks (integer truncation, BAUD_DIV >= 4)
DATA_BITS, 8, frame data bits, legal 5..8
FIFO_DEPTH, 8, entries per FIFO, power of two, >= 2
SEL_CODE, 2'b10, psel value that selects this slave

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pAdd  in  32  APB address; only pAdd[3:2] decoded
pwData  in  32  APB write data
pwr  in  1  1 = write, 0 = read
psel  in  2  slave select; this block is selected when psel == SEL_CODE
pen  in  1  APB enable (access phase)
rxd  in  1  serial input, idle high
prdata  out  32  APB read data
pready  out  1  transfer complete
txd  out  1  serial output, idle high
irq  out  1  level interrupt
err_out  out  1  OR of sticky error flags

Behaviour:
- Reset (async, rst_n low): txd=1, prdata=0, pready=0, irq=0, err_out=0. FIFOs empty, both FSMs IDLE, CTRL=0, error flags=0. Reset mid-frame aborts the frame immediately and leaves txd high.
- APB: access when psel==SEL_CODE && pen. pready=1 combinationally in the access cycle, giving zero wait states. Side effects commit on that cycle's rising edge. prdata is combinational during access and 0 otherwise.
- Register map (pAdd[3:2]):
  - 0 DATA. Write pushes pwData[DATA_BITS-1:0] into the TX FIFO. Read pops the RX FIFO and returns the byte zero-extended.
  - 1 STATUS (RO). Bits: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] tx_busy, [5] rx_busy, [15:8] rx_count.
  - 2 CTRL (RW). Bits: [0] tx_en, [1] rx_en, [2] parity_en, [3] parity_odd, [4] two_stop, [5] ie_rx, [6] ie_tx, [7] ie_err.
  - 3 ERR. Sticky flags: [0] frame, [1] parity, [2] rx_overrun, [3] tx_overflow. Writing 1 clears a flag; writing 0 has no effect.
- DATA write with TX FIFO full: data dropped, tx_overflow set. DATA read with RX FIFO empty: returns 0, no pop, no error.
- TX FSM, states IDLE -> START -> DATA -> PARITY -> STOP -> IDLE:
  - Each state lasts BAUD_DIV clocks, except STOP, which lasts 2*BAUD_DIV when two_stop=1.
  - PARITY is skipped when parity_en=0.
  - LSB is sent first. Parity bit = XOR of data bits, inverted when parity_odd=1.
  - Leaves IDLE when tx_en=1 and the FIFO is not empty, popping one entry on the transition. txd goes low on the cycle after the pop.
  - Clearing tx_en mid-frame lets the current frame finish, then the FSM stays IDLE.
  - Back-to-back frames: START follows STOP with no idle gap when data is available.
- RX FSM, states IDLE -> START -> DATA -> PARITY -> STOP -> IDLE:
  - rxd passes through a 2-flop synchroniser.
  - IDLE: a falling edge while rx_en=1 enters START.
  - START: samples at BAUD_DIV/2. If rxd is high the start is false, return to IDLE with no error.
  - Later bits are sampled every BAUD_DIV clocks from the mid-start point. Only one stop bit is checked, whatever two_stop says.
  - Stop sampled 0 sets the frame flag, and the byte is discarded. Parity mismatch sets the parity flag, and the byte is discarded.
  - A good byte with the RX FIFO full is dropped and sets rx_overrun.
  - A push and a pop in the same cycle are both honoured; the count is unchanged.
  - Clearing rx_en mid-frame finishes the current frame.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits, with a wrap bit distinguishing full from empty. Pointers wrap modulo 2*FIFO_DEPTH.
- err_out = |ERR.
- irq = (ie_rx & ~rx_empty) | (ie_tx & tx_empty) | (ie_err & err_out). Registered: asserts one clock after the condition.

Test Plan:
All scenarios use CLOCK_RATE=1_000_000, BAUD_RATE=100_000 (BAUD_DIV=10) and DATA_BITS=8.
- Loopback (txd to rxd): CTRL=0x03, write DATA=0xA5 -> txd low 10 clks, then bits 1,0,1,0,0,1,0,1, then high. STATUS rx_empty=0 after ~100 clks. DATA read returns 0x000000A5.
- Parity: CTRL=0x0F (even parity off, odd parity on), write 0x03 -> parity bit 1, frame 110 clks. Inject a frame with a flipped parity bit on rxd -> ERR=0x2, err_out=1, RX FIFO still empty. Write ERR=0x2 -> err_out=0.
- Overflow: tx_en=0, write 9 bytes 0x00..0x08 -> tx_full=1, ERR[3]=1. Set tx_en=1 -> exactly 8 frames, 0x00..0x07, with no idle gap between them.
- RX overrun: 9 frames received without reads -> rx_full=1, rx_count=8, ERR[2]=1. Reads return the first 8 bytes in order, then 0.
- Framing/glitch: 3-clk low pulse on rxd -> no byte, no error. Frame with stop=0 -> ERR[0]=1, irq=1 when ie_err=1.
- Reset mid-frame: assert rst_n low at clk 40 of a TX frame -> txd=1 immediately, STATUS reads 0x0A (both FIFOs empty), CTRL=0.

Source files
------------

// File: rtl/apb_uart_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_uart_fifo_if
// Purpose  : APB slave-side signal bundle for the FIFO UART peripheral.
// Revision : 1.0 - initial release
// ============================================================================
interface apb_uart_fifo_if;
  logic [31:0] pAdd;
  logic [31:0] pwData;
  logic        pwr;
  logic [1:0]  psel;
  logic        pen;
  logic [31:0] prdata;
  logic        pready;

  modport master (
    output pAdd, pwData, pwr, psel, pen,
    input  prdata, pready
  );

  modport slave (
    input  pAdd, pwData, pwr, psel, pen,
    output prdata, pready
  );
endinterface
`default_nettype wire

// File: rtl/apb_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module   : apb_uart_fifo
// Purpose  : APB-attached UART with TX/RX FIFOs, runtime parity and stop-bit
//            modes, sticky error flags and a registered level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module apb_uart_fifo #(
  parameter int         CLOCK_RATE = 50_000_000,
  parameter int         BAUD_RATE  = 9600,
  parameter int         DATA_BITS  = 8,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [1:0] SEL_CODE   = 2'b10
) (
  input  logic             clk,
  input  logic             rst_n,
  apb_uart_fifo_if.slave   apb,
  input  logic             rxd,
  output logic             txd,
  output logic             irq,
  output logic             err_out
);

  localparam int BAUD_DIV = CLOCK_RATE / BAUD_RATE;
  localparam int CW       = $clog2(2 * BAUD_DIV);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int PW       = AW + 1;
  localparam int BW       = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BAUD_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] STOP2_LAST = CW'(2 * BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);
  localparam logic [PW-1:0] DEPTH_P    = PW'(FIFO_DEPTH);

  // Shared state encoding for both serial engines
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // ---------------------------------------------------------------- APB decode
  logic        access;
  logic [1:0]  addr;
  logic        data_wr, data_rd, ctrl_wr, err_wr;
  logic [7:0]  ctrl;
  logic [3:0]  err;
  logic [31:0] rd_mux;
  logic        unused_bits;

  assign access  = (apb.psel == SEL_CODE) && apb.pen;
  assign addr    = apb.pAdd[3:2];
  assign data_wr = access &&  apb.pwr && (addr == 2'd0);
  assign data_rd = access && !apb.pwr && (addr == 2'd0);
  assign ctrl_wr = access &&  apb.pwr && (addr == 2'd2);
  assign err_wr  = access &&  apb.pwr && (addr == 2'd3);
  assign apb.pready = access;
  assign unused_bits = ^{apb.pAdd[31:4], apb.pAdd[1:0], apb.pwData[31:8]};

  logic tx_en, rx_en, parity_en, parity_odd, two_stop, ie_rx, ie_tx, ie_err;
  assign tx_en      = ctrl[0];
  assign rx_en      = ctrl[1];
  assign parity_en  = ctrl[2];
  assign parity_odd = ctrl[3];
  assign two_stop   = ctrl[4];
  assign ie_rx      = ctrl[5];
  assign ie_tx      = ctrl[6];
  assign ie_err     = ctrl[7];

  // ------------------------------------------------------------------ TX FIFO
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [PW-1:0]        tx_wp, tx_rp, tx_count;
  logic                 tx_full, tx_empty, tx_push, tx_pop, tx_ovf;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_count = tx_wp - tx_rp;
  assign tx_full  = (tx_count == DEPTH_P);
  assign tx_empty = (tx_wp == tx_rp);
  assign tx_push  = data_wr && !tx_full;
  assign tx_ovf   = data_wr &&  tx_full;
  assign tx_head  = tx_mem[tx_rp[AW-1:0]];

  // TX FIFO storage; no reset needed, validity tracked by the pointers
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= apb.pwData[DATA_BITS-1:0];
  end

  // TX FIFO pointers, wrap bit distinguishes full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
    end
  end

  // ------------------------------------------------------------------ TX FSM
  logic [2:0]           tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par, tx_pen_l, tx_two_l;
  logic [CW-1:0]        tx_stop_last;
  logic                 tx_bit_end, tx_stop_end;

  assign tx_stop_last = tx_two_l ? STOP2_LAST : BAUD_LAST;
  assign tx_bit_end   = (tx_cnt == BAUD_LAST);
  assign tx_stop_end  = (tx_cnt == tx_stop_last);
  // A new frame starts from IDLE or straight out of STOP, so back-to-back
  // frames have no idle gap
  assign tx_pop = tx_en && !tx_empty &&
                  ((tx_state == S_IDLE) || ((tx_state == S_STOP) && tx_stop_end));

  // Transmit engine; frame settings are latched when a frame starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx_pen_l <= 1'b0;
      tx_two_l <= 1'b0;
      txd      <= 1'b1;
    end else if (tx_pop) begin
      tx_state <= S_START;
      tx_cnt   <= '0;
      tx_sh    <= tx_head;
      tx_par   <= (^tx_head) ^ parity_odd;
      tx_pen_l <= parity_en;
      tx_two_l <= two_stop;
      txd      <= 1'b0;
    end else begin
      case (tx_state)
        S_START: begin
          if (tx_bit_end) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            txd      <= tx_sh[0];
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_bit == BIT_LAST) begin
              tx_state <= tx_pen_l ? S_PARITY : S_STOP;
              txd      <= tx_pen_l ? tx_par : 1'b1;
            end else begin
              tx_bit <= tx_bit + 1'b1;
              tx_sh  <= tx_sh >> 1;
              txd    <= tx_sh[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (tx_bit_end) begin
            tx_cnt   <= '0;
            txd      <= 1'b1;
            tx_state <= S_STOP;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (tx_stop_end) begin
            tx_cnt   <= '0;
            tx_state <= S_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          tx_state <= S_IDLE;
          txd      <= 1'b1;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------ RX sync
  logic rx_s1, rxs, rx_prev;

  // Two-flop synchroniser plus one delay stage for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rxs     <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rxd;
      rxs     <= rx_s1;
      rx_prev <= rxs;
    end
  end

  // ------------------------------------------------------------------ RX FIFO
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [PW-1:0]        rx_wp, rx_rp, rx_count;
  logic                 rx_full, rx_empty, rx_push, rx_pop, rx_ovr, rx_good;
  logic [DATA_BITS-1:0] rx_head;
  logic [DATA_BITS-1:0] rx_sh;

  assign rx_count = rx_wp - rx_rp;
  assign rx_full  = (rx_count == DEPTH_P);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_pop   = data_rd && !rx_empty;
  assign rx_push  = rx_good && (!rx_full || rx_pop);
  assign rx_ovr   = rx_good &&   rx_full && !rx_pop;
  assign rx_head  = rx_mem[rx_rp[AW-1:0]];

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
  end

  // RX FIFO pointers; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
    end
  end

  // ------------------------------------------------------------------ RX FSM
  logic [2:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [BW-1:0] rx_bit;
  logic          rx_pen_l, rx_odd_l, rx_par_bad;
  logic          rx_bit_end, rx_stop_smp, rx_frame_err, rx_par_err;

  assign rx_bit_end   = (rx_cnt == BAUD_LAST);
  assign rx_stop_smp  = (rx_state == S_STOP) && rx_bit_end;
  assign rx_frame_err = rx_stop_smp && !rxs;
  assign rx_par_err   = rx_stop_smp && rx_par_bad;
  assign rx_good      = rx_stop_smp && rxs && !rx_par_bad;

  // Receive engine; samples mid-bit, checks only the first stop bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= S_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_sh      <= '0;
      rx_pen_l   <= 1'b0;
      rx_odd_l   <= 1'b0;
      rx_par_bad <= 1'b0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          rx_cnt <= '0;
          if (rx_en && rx_prev && !rxs) rx_state <= S_START;
        end
        S_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            if (rxs) begin
              rx_state <= S_IDLE;
            end else begin
              rx_state   <= S_DATA;
              rx_bit     <= '0;
              rx_par_bad <= 1'b0;
              rx_pen_l   <= parity_en;
              rx_odd_l   <= parity_odd;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_bit_end) begin
            rx_cnt <= '0;
            rx_sh  <= {rxs, rx_sh[DATA_BITS-1:1]};
            if (rx_bit == BIT_LAST) rx_state <= rx_pen_l ? S_PARITY : S_STOP;
            else                    rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (rx_bit_end) begin
            rx_cnt     <= '0;
            rx_par_bad <= (rxs != ((^rx_sh) ^ rx_odd_l));
            rx_state   <= S_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (rx_bit_end) begin
            rx_cnt   <= '0;
            rx_state <= S_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------- CTRL / ERR / IRQ
  logic [3:0] err_set, err_clr;
  assign err_set = {tx_ovf, rx_ovr, rx_par_err, rx_frame_err};
  assign err_clr = err_wr ? apb.pwData[3:0] : 4'b0;
  assign err_out = |err;

  // Control register and write-1-to-clear sticky errors (new events win)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl <= '0;
      err  <= '0;
    end else begin
      if (ctrl_wr) ctrl <= apb.pwData[7:0];
      err <= (err & ~err_clr) | err_set;
    end
  end

  // Registered level interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= (ie_rx & ~rx_empty) | (ie_tx & tx_empty) | (ie_err & err_out);
  end

  // --------------------------------------------------------------- read mux
  logic tx_busy, rx_busy;
  assign tx_busy = (tx_state != S_IDLE);
  assign rx_busy = (rx_state != S_IDLE);

  // Register read data; presented only during a read access
  always_comb begin
    rd_mux = '0;
    case (addr)
      2'd0:    rd_mux = rx_empty ? 32'd0 : 32'(rx_head);
      2'd1:    rd_mux = {16'b0, 8'(rx_count), 2'b0, rx_busy, tx_busy,
                         rx_empty, rx_full, tx_empty, tx_full};
      2'd2:    rd_mux = {24'b0, ctrl};
      default: rd_mux = {28'b0, err};
    endcase
  end

  assign apb.prdata = (access && !apb.pwr) ? rd_mux : 32'd0;

endmodule
`default_nettype wire
